// File: rtl/imem_harness.sv
// rtl/imem_harness.sv - instruction memory and run/halt control for the single-cycle datapath
//
// Ports:
//   i_clk, i_rst (async, active-high), i_clear (sync return to IDLE)
//   i_load_valid / i_load_byte / i_load_last / o_load_ready : byte-serial program load
//   i_start                         : begin or re-run execution
//   i_fetch_addr / o_fetch_instr    : little-endian word fetch, low two address bits ignored
//   o_dp_en, o_halted, o_halt_cause : datapath gating and halt status (cause 1 = budget)
//   o_cycle_cnt, o_load_count, o_state : observability (IDLE=00 LOAD=01 RUN=10 HALT=11)
module imem_harness #(
  parameter int          ADDR_W     = 12,
  parameter int          MAX_CYCLES = 1024,
  parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  input  logic              i_load_last,
  output logic              o_load_ready,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [31:0]       o_fetch_instr,
  output logic              o_dp_en,
  output logic              o_halted,
  output logic              o_halt_cause,
  output logic [31:0]       o_cycle_cnt,
  output logic [ADDR_W:0]   o_load_count,
  output logic [1:0]        o_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W+1)'(DEPTH);
  localparam logic [31:0]     LAST_CYCLE  = 32'(MAX_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  logic [7:0]        r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_load_count;
  logic [31:0]       r_cycle_cnt;
  logic              r_halt_cause;

  logic [ADDR_W-1:0] w_addr;
  logic              w_loading;
  logic              w_accept;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_load_done;

  // Word-align the PC; masking (rather than slicing) keeps every address bit in use.
  assign w_addr        = i_fetch_addr & ~ADDR_W'(3);
  assign o_fetch_instr = {r_mem[w_addr + ADDR_W'(3)], r_mem[w_addr + ADDR_W'(2)],
                          r_mem[w_addr + ADDR_W'(1)], r_mem[w_addr]};

  assign w_loading    = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign o_load_ready = w_loading && (r_load_count < DEPTH_C);
  assign w_accept     = i_load_valid && o_load_ready;
  assign w_count_inc  = r_load_count + (ADDR_W+1)'(1);
  // A load burst ends on the tagged last byte or when the array fills up.
  assign w_load_done  = i_load_last || (w_count_inc == DEPTH_C);

  assign o_dp_en      = (r_state == S_RUN);
  assign o_halted     = (r_state == S_HALT);
  assign o_halt_cause = r_halt_cause;
  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_load_count = r_load_count;
  assign o_state      = r_state;

  // Memory has no reset; a byte offered alongside rst or clear is dropped.
  always_ff @(posedge i_clk) begin
    if (w_accept && !i_rst && !i_clear) begin
      r_mem[r_load_count[ADDR_W-1:0]] <= i_load_byte;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_load_count <= '0;
      r_cycle_cnt  <= '0;
      r_halt_cause <= 1'b0;
    end else if (i_clear) begin
      r_state      <= S_IDLE;
      r_load_count <= '0;
      r_cycle_cnt  <= '0;
      r_halt_cause <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_load_count <= w_count_inc;
            r_state      <= w_load_done ? S_IDLE : S_LOAD;
          end else if (i_start && (r_load_count != '0)) begin
            r_state      <= S_RUN;
            r_cycle_cnt  <= '0;
            r_halt_cause <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_load_count <= w_count_inc;
            if (w_load_done) r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
          // The halt instruction wins over the budget on the same edge.
          if (o_fetch_instr == HALT_INSTR) begin
            r_state      <= S_HALT;
            r_halt_cause <= 1'b0;
          end else if (r_cycle_cnt == LAST_CYCLE) begin
            r_state      <= S_HALT;
            r_halt_cause <= 1'b1;
          end
        end
        default: begin
          if (i_start) begin
            r_state      <= S_RUN;
            r_cycle_cnt  <= '0;
            r_halt_cause <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_harness.sv
// tb/tb_imem_harness.sv - directed self-checking bench for imem_harness
module tb_imem_harness;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_last = 1'b0;
  logic        start = 1'b0;
  logic [11:0] fetch_addr = '0;
  logic        load_ready, dp_en, halted, halt_cause;
  logic [31:0] fetch_instr, cycle_cnt;
  logic [12:0] load_count;
  logic [1:0]  state;

  logic        s_clear = 1'b0;
  logic        s_load_valid = 1'b0;
  logic [7:0]  s_load_byte = 8'h00;
  logic [3:0]  s_fetch_addr = '0;
  logic        s_load_ready, s_dp_en, s_halted, s_halt_cause;
  logic [31:0] s_fetch_instr, s_cycle_cnt;
  logic [4:0]  s_load_count;
  logic [1:0]  s_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_harness #(.ADDR_W(12), .MAX_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear),
    .i_load_valid(load_valid), .i_load_byte(load_byte), .i_load_last(load_last),
    .o_load_ready(load_ready), .i_start(start), .i_fetch_addr(fetch_addr),
    .o_fetch_instr(fetch_instr), .o_dp_en(dp_en), .o_halted(halted),
    .o_halt_cause(halt_cause), .o_cycle_cnt(cycle_cnt), .o_load_count(load_count),
    .o_state(state)
  );

  imem_harness #(.ADDR_W(4), .MAX_CYCLES(16)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_clear(s_clear),
    .i_load_valid(s_load_valid), .i_load_byte(s_load_byte), .i_load_last(1'b0),
    .o_load_ready(s_load_ready), .i_start(1'b0), .i_fetch_addr(s_fetch_addr),
    .o_fetch_instr(s_fetch_instr), .o_dp_en(s_dp_en), .o_halted(s_halted),
    .o_halt_cause(s_halt_cause), .o_cycle_cnt(s_cycle_cnt), .o_load_count(s_load_count),
    .o_state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    chk("rst_dp_en", 32'(dp_en), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cause", 32'(halt_cause), 32'h0);
    chk("rst_cycle_cnt", cycle_cnt, 32'h0);
    chk("rst_load_count", 32'(load_count), 32'h0);
    chk("rst_small_ready", 32'(s_load_ready), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    // Program load: first byte moves to LOAD, tagged last byte returns to IDLE.
    send(8'h13, 1'b0);
    chk("load_first_state", 32'(state), 32'h1);
    send(8'h06, 1'b0);
    send(8'h50, 1'b0);
    send(8'h00, 1'b0);
    send(8'h93, 1'b0);
    send(8'h66, 1'b0);
    send(8'hB0, 1'b0);
    send(8'h00, 1'b1);
    chk("load8_count", 32'(load_count), 32'd8);
    chk("load8_state", 32'(state), 32'h0);
    fetch_addr = 12'd0; #1;
    chk("fetch_0", fetch_instr, 32'h00500613);
    fetch_addr = 12'd4; #1;
    chk("fetch_4", fetch_instr, 32'h00B06693);
    fetch_addr = 12'd6; #1;
    chk("fetch_6", fetch_instr, 32'h00B06693);

    // Start with nothing pending is blocked only when empty; here count is 8.
    send(8'h73, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    chk("load12_count", 32'(load_count), 32'd12);
    fetch_addr = 12'd0;
    pulse_start();
    chk("run_state", 32'(state), 32'h2);
    chk("run_dp_en", 32'(dp_en), 32'h1);
    chk("run_ready", 32'(load_ready), 32'h0);
    chk("run_cnt0", cycle_cnt, 32'd0);
    tick();
    fetch_addr = 12'd4;
    tick();
    fetch_addr = 12'd8; #1;
    chk("fetch_halt", fetch_instr, 32'h00000073);
    tick();
    chk("halt_state", 32'(state), 32'h3);
    chk("halt_cnt", cycle_cnt, 32'd3);
    chk("halt_cause_instr", 32'(halt_cause), 32'h0);
    chk("halt_dp_en", 32'(dp_en), 32'h0);
    chk("halt_halted", 32'(halted), 32'h1);

    // Budget exhaustion with the PC parked on a non-halt word.
    fetch_addr = 12'd0;
    pulse_start();
    repeat (15) tick();
    chk("budget_15_state", 32'(state), 32'h2);
    chk("budget_15_cnt", cycle_cnt, 32'd15);
    tick();
    chk("budget_state", 32'(state), 32'h3);
    chk("budget_cnt", cycle_cnt, 32'd16);
    chk("budget_cause", 32'(halt_cause), 32'h1);
    tick();
    chk("budget_hold_cnt", cycle_cnt, 32'd16);
    pulse_start();
    chk("rerun_cause_clr", 32'(halt_cause), 32'h0);
    repeat (16) tick();
    chk("rerun_cnt", cycle_cnt, 32'd16);
    chk("rerun_cause", 32'(halt_cause), 32'h1);

    // Asynchronous reset in the middle of a run.
    pulse_start();
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_state", 32'(state), 32'h0);
    chk("midrun_rst_cnt", cycle_cnt, 32'd0);
    chk("midrun_rst_lcnt", 32'(load_count), 32'd0);
    chk("midrun_rst_fetch", fetch_instr, 32'h00500613);
    tick();
    rst = 1'b0;
    tick();

    // Reload from address 0 with a lone halt word: stops after one cycle.
    send(8'h73, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    fetch_addr = 12'd0; #1;
    chk("reload_fetch", fetch_instr, 32'h00000073);
    pulse_start();
    tick();
    chk("one_cycle_state", 32'(state), 32'h3);
    chk("one_cycle_cnt", cycle_cnt, 32'd1);

    // clear outranks start in HALT.
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clear_state", 32'(state), 32'h0);
    chk("clear_lcnt", 32'(load_count), 32'd0);
    chk("clear_cnt", cycle_cnt, 32'd0);
    pulse_start();
    chk("start_empty_ignored", 32'(state), 32'h0);
    send(8'hAA, 1'b0);
    fetch_addr = 12'd0; #1;
    chk("overwrite_addr0", fetch_instr, 32'h000000AA);

    // Small array: 17 bytes offered, only 16 fit.
    s_load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_load_byte = 8'(8'h10 + i);
      tick();
    end
    s_load_valid = 1'b0;
    chk("full_count", 32'(s_load_count), 32'd16);
    chk("full_ready", 32'(s_load_ready), 32'h0);
    chk("full_state", 32'(s_state), 32'h0);
    s_fetch_addr = 4'd0; #1;
    chk("full_word0", s_fetch_instr, 32'h13121110);
    s_fetch_addr = 4'd12; #1;
    chk("full_word3", s_fetch_instr, 32'h1F1E1D1C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
